// File: rtl/lsu_ctrl.sv
// Load/store sequencer: execute-stage request to byte-addressed data memory.
// Optional define LSU_ALIGN_CHK_EN enables misaligned/illegal error responses.
module lsu_ctrl #(
    parameter int XLEN = 32,
    parameter int BC   = XLEN / 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [1:0]      rsp_err,
    output logic            mem_gwe,
    output logic [BC-1:0]   mem_bw,
    output logic            mem_rd,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_LWAIT  = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]      state;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] rdata_q;
    logic [1:0]      err_q;

    logic            f3_ok;
    logic            misal;
    logic [2:0]      f3_d;
    logic [XLEN-1:0] addr_d;
    logic [1:0]      err_d;

    always_comb begin
        if (req_we)
            f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
        else
            f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                    (req_funct3 == 3'b101);
        misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

`ifdef LSU_ALIGN_CHK_EN
    always_comb begin
        f3_d   = req_funct3;
        addr_d = req_addr;
        err_d  = 2'b00;
        if (!f3_ok)
            err_d = 2'b10;
        else if (misal)
            err_d = 2'b01;
    end
`else
    // Without checking, illegal encodings become word accesses and the
    // address is snapped down to the access size.
    always_comb begin
        f3_d   = f3_ok ? req_funct3 : 3'b010;
        addr_d = req_addr;
        err_d  = 2'b00;
        if (f3_d[1:0] == 2'b01)
            addr_d[0] = 1'b0;
        else if (f3_d[1:0] == 2'b10)
            addr_d[1:0] = 2'b00;
    end
`endif

    logic [1:0]      b;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ld_ext;

    always_comb begin
        b        = addr_q[1:0];
        byte_sel = mem_rdata[{b, 3'b000} +: 8];
        half_sel = mem_rdata[{b[1], 4'b0000} +: 16];
        unique case (f3_q[1:0])
            2'b00:   ld_ext = {{(XLEN-8){~f3_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   ld_ext = {{(XLEN-16){~f3_q[2] & half_sel[15]}}, half_sel};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 2'b00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= f3_d;
                        addr_q  <= addr_d;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= err_d;
                        state   <= (err_d != 2'b00) ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: state <= we_q ? S_RESP : S_LWAIT;
                S_LWAIT: begin
                    rdata_q <= ld_ext;
                    state   <= S_RESP;
                end
                default: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are purely combinational on state so reset kills them at once.
    always_comb begin
        mem_gwe = 1'b0;
        mem_bw  = '0;
        mem_rd  = 1'b0;
        if (state == S_ACCESS) begin
            if (!we_q)
                mem_rd = 1'b1;
            else begin
                unique case (1'b1)
                    (f3_q[1:0] == 2'b00): mem_bw = 4'b0001 << b;
                    (f3_q[1:0] == 2'b01): mem_bw = b[1] ? 4'b1100 : 4'b0011;
                    default:              mem_gwe = 1'b1;
                endcase
            end
        end
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a byte-lane memory model.
// Covers both LSU_ALIGN_CHK_EN builds.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        mem_gwe, mem_rd;
    logic [3:0]  mem_bw;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_gwe(mem_gwe), .mem_bw(mem_bw), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory: halves land in lanes from data_in[15:0], bytes from [7:0].
    logic [31:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    always @(posedge clk) begin
        if (mem_gwe)
            mem[mem_addr[7:2]] <= mem_wdata;
        else
            for (int i = 0; i < 4; i++)
                if (mem_bw[i])
                    mem[mem_addr[7:2]][8*i +: 8] <=
                        (mem_bw == 4'b0011 || mem_bw == 4'b1100) ?
                        mem_wdata[8*(i%2) +: 8] : mem_wdata[7:0];
        if (mem_rd)
            mem_rdata <= mem[mem_addr[7:2]];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] maddr;
        logic [31:0] rdata;
        logic [1:0]  err;
        int          lat;
        logic        gwe;
        logic [3:0]  bw;
        logic        rd;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] ma,
                                logic [31:0] rd_exp, logic [1:0] e,
                                logic g, logic [3:0] bw, logic r);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.maddr = ma;
        v.rdata = rd_exp; v.err = e; v.gwe = g; v.bw = bw; v.rd = r;
        v.lat = (e != 2'b00) ? 1 : (we ? 2 : 3);
        return v;
    endfunction

    task automatic run_vec(input string tag, input vec_t v);
        int lat = 0;
        int nstb = 0;
        logic cg = 0, cr = 0, bad = 0;
        logic [3:0] cb = 0;
        logic [31:0] ca = 0, cw = 0;
        @(negedge clk);
        req_valid = 1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if ((32'(mem_gwe) + 32'(|mem_bw) + 32'(mem_rd)) > 1) bad = 1;
            if (mem_gwe || mem_rd || |mem_bw) begin
                nstb++; ca = mem_addr; cw = mem_wdata;
            end
            cg |= mem_gwe; cr |= mem_rd; cb |= mem_bw;
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        chk({tag, " strobe cycles"}, 32'(nstb), (v.err != 0) ? 0 : 1);
        chk({tag, " strobe overlap"}, 32'(bad), 32'd0);
        chk({tag, " gwe"}, 32'(cg), 32'(v.gwe));
        chk({tag, " bw"}, 32'(cb), 32'(v.bw));
        chk({tag, " rd"}, 32'(cr), 32'(v.rd));
        if (v.err == 0) chk({tag, " mem_addr"}, ca, v.maddr);
        if (v.we && v.err == 0) chk({tag, " mem_wdata"}, cw, v.wdata);
        chk({tag, " rdata"}, rsp_rdata, v.rdata);
        chk({tag, " err"}, 32'(rsp_err), 32'(v.err));
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        @(negedge clk);
        chk({tag, " req_ready after rsp"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid after rsp"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, " strobes"}, {27'h0, mem_gwe, mem_bw, mem_rd}, 32'h0);
        chk({tag, " mem_addr"}, mem_addr, 32'h0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        vq.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h10, 0, 0, 1, 4'b0000, 0));
        vq.push_back(mk(0, 3'b010, 32'h10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 4'b0000, 1));
        vq.push_back(mk(0, 3'b000, 32'h13, 0, 32'h13, 32'hFFFFFFDE, 0, 0, 4'b0000, 1));
        vq.push_back(mk(0, 3'b000, 32'h10, 0, 32'h10, 32'hFFFFFFEF, 0, 0, 4'b0000, 1));
        vq.push_back(mk(0, 3'b101, 32'h12, 0, 32'h12, 32'h0000DEAD, 0, 0, 4'b0000, 1));
        vq.push_back(mk(1, 3'b000, 32'h21, 32'h000000A5, 32'h21, 0, 0, 0, 4'b0010, 0));
        vq.push_back(mk(0, 3'b000, 32'h21, 0, 32'h21, 32'hFFFFFFA5, 0, 0, 4'b0000, 1));
        vq.push_back(mk(0, 3'b100, 32'h21, 0, 32'h21, 32'h000000A5, 0, 0, 4'b0000, 1));
        vq.push_back(mk(1, 3'b001, 32'h32, 32'h00008001, 32'h32, 0, 0, 0, 4'b1100, 0));
        vq.push_back(mk(0, 3'b001, 32'h32, 0, 32'h32, 32'hFFFF8001, 0, 0, 4'b0000, 1));
        vq.push_back(mk(0, 3'b101, 32'h30, 0, 32'h30, 32'h00000000, 0, 0, 4'b0000, 1));
        vq.push_back(mk(1, 3'b001, 32'h34, 32'hFFFF1234, 32'h34, 0, 0, 0, 4'b0011, 0));
        vq.push_back(mk(0, 3'b010, 32'h34, 0, 32'h34, 32'h00001234, 0, 0, 4'b0000, 1));
        vq.push_back(mk(1, 3'b010, 32'h50, 32'hCAFEF00D, 32'h50, 0, 0, 1, 4'b0000, 0));
`ifdef LSU_ALIGN_CHK_EN
        vq.push_back(mk(0, 3'b010, 32'h41, 0, 0, 0, 2'b01, 0, 4'b0000, 0));
        vq.push_back(mk(1, 3'b001, 32'h43, 32'h5566, 0, 0, 2'b01, 0, 4'b0000, 0));
        vq.push_back(mk(0, 3'b011, 32'h40, 0, 0, 0, 2'b10, 0, 4'b0000, 0));
        vq.push_back(mk(1, 3'b100, 32'h40, 32'h1, 0, 0, 2'b10, 0, 4'b0000, 0));
`else
        vq.push_back(mk(1, 3'b010, 32'h40, 32'h11223344, 32'h40, 0, 0, 1, 4'b0000, 0));
        vq.push_back(mk(0, 3'b010, 32'h41, 0, 32'h40, 32'h11223344, 0, 0, 4'b0000, 1));
        vq.push_back(mk(1, 3'b001, 32'h43, 32'h00005566, 32'h42, 0, 0, 0, 4'b1100, 0));
        vq.push_back(mk(0, 3'b011, 32'h40, 0, 32'h40, 32'h55663344, 0, 0, 4'b0000, 1));
`endif

        rst_n = 0; req_valid = 0; req_we = 0; req_funct3 = 0;
        req_addr = 0; req_wdata = 0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1;

        foreach (vq[i]) run_vec($sformatf("v%0d", i), vq[i]);

        // Stalled consumer with a request waiting behind it.
        @(negedge clk);
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
        req_funct3 = 3'b100; req_addr = 32'h21;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall hold valid", 32'(rsp_valid), 32'd1);
            chk("stall hold data", rsp_rdata, 32'hDEADBEEF);
            chk("stall req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        chk("stall idle ready", 32'(req_ready), 32'd1);
        chk("stall idle valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 0;
        chk("stall next accepted", 32'(mem_rd), 32'd1);
        chk("stall next busy", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("stall next rdata", rsp_rdata, 32'h000000A5);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;

        // Reset in the middle of a store's ACCESS cycle.
        @(negedge clk);
        req_valid = 1; req_we = 1; req_funct3 = 3'b010;
        req_addr = 32'h50; req_wdata = 32'h12345678;
        @(posedge clk);
        #1 req_valid = 0;
        #1 chk("rst pre gwe", 32'(mem_gwe), 32'd1);
        rst_n = 0;
        #1 chk_reset_vals("rst mid");
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst held");
        rst_n = 1;
        run_vec("rst reload", mk(0, 3'b010, 32'h50, 0, 32'h50,
                                 32'hCAFEF00D, 0, 0, 4'b0000, 1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the core's execute stage and the byte-addressable data memory. Accepts one RISC-V load or store per handshake and decodes `funct3` and address bits into the memory's global-write, byte-write and read strobes. Formats the returned word: lane select, then sign or zero extension. Returns a single response per request, carrying an error flag for misaligned or illegal accesses.

## Interface
- `XLEN`, 32, data/address width; only 32 is supported.
- `BC`, `XLEN/8`, bytes per word (4).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I `funct3`. Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010.
- `req_addr`  in  XLEN  byte address.
- `req_wdata`  in  XLEN  store data, LSB-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes response.
- `rsp_rdata`  out  XLEN  extended load data; 0 for stores and errors.
- `rsp_err`  out  2  00 ok, 01 misaligned, 10 illegal `funct3`.
- `mem_gwe`  out  1  to memory `gwe`, full-word write.
- `mem_bw`  out  4  to memory `bw3..bw0`.
- `mem_rd`  out  1  to memory `rd`.
- `mem_addr`  out  XLEN  to memory `addr`: the registered request address.
- `mem_wdata`  out  XLEN  to memory `data_in`: the registered `req_wdata`, unshifted.
- `mem_rdata`  in  XLEN  from memory `data_out`; registered there, valid one cycle after `mem_rd`.

## Operation
- FSM states: IDLE, ACCESS, LWAIT, RESP.
- IDLE
  - `req_ready`=1 only in IDLE.
  - Handshake `req_valid && req_ready` latches `we`, `funct3`, `addr`, `wdata`.
  - Checks `funct3` validity and alignment: half needs `addr[0]`=0; word needs `addr[1:0]`=00.
  - Error → RESP with `rsp_err` set; no memory strobe.
  - Otherwise → ACCESS.
- ACCESS, exactly one cycle; strobes decoded combinationally from state and latched request:
  - SW: `mem_gwe`=1, `mem_bw`=0000.
  - SH at `b`=00: `mem_bw`=0011. SH at `b`=10: `mem_bw`=1100.
  - SB: `mem_bw` is one-hot at bit `b`.
  - Load: `mem_rd`=1.
  - Store → RESP. Load → LWAIT.
- LWAIT, one cycle: select lane from `mem_rdata` using `b`.
  - Byte = bits `[8b+7:8b]`; half = bits `[16·b[1]+15:16·b[1]]`.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Register the result into `rsp_rdata` → RESP.
- RESP: `rsp_valid`=1 and `rsp_rdata`/`rsp_err` held stable until `rsp_ready`. On `rsp_ready` → IDLE.
- Strobes are 0 in every state except ACCESS. No two strobes are ever active together.
- Store data is passed unshifted because the memory places `data_in[7:0]` / `[15:8]` into the addressed lanes itself.

## Timing
- Reset values: state IDLE. `req_ready`=1; `rsp_valid`=0; `rsp_rdata`=0; `rsp_err`=00. `mem_gwe`, `mem_bw`, `mem_rd`=0; `mem_addr`, `mem_wdata`=0.
- Request accepted at edge T.
  - Store: ACCESS in cycle T+1, memory write at edge T+2, `rsp_valid` in cycle T+2.
  - Load: `mem_rd` in T+1, data in T+2, `rsp_valid` in T+3.
  - Error: `rsp_valid` in T+1.
- Response handshake at edge R: `req_ready`=1 in R+1. There is no same-cycle response-to-request bypass. Throughput: one load per 4 cycles; one store per 3.
- `rsp_valid` never drops without `rsp_ready`. Stalled consumer: FSM holds RESP indefinitely; no new requests accepted.
- `req_*` inputs are ignored outside IDLE.
- Reset mid-operation: all outputs return to reset values immediately, so strobes drop before the next edge and no memory write occurs. Any pending response is discarded.

## Configuration
- `LSU_ALIGN_CHK_EN` defined: misaligned and illegal checks as above; `rsp_err` is driven.
- `LSU_ALIGN_CHK_EN` undefined: no error path, and `rsp_err` is tied to 00.
  - Address low bits are forced: half clears `addr[0]`, word clears `addr[1:0]`, applied to `mem_addr` and lane select.
  - Illegal `funct3` is treated as LW/SW.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → store `rsp_valid` at T+2 with `mem_gwe` pulsed once; load `rsp_rdata`=0xDEADBEEF at T+3, `rsp_err`=00.
- SB 0x000000A5 @0x21, then LB @0x21 and LBU @0x21 → `mem_bw`=0010 for one cycle; responses 0xFFFFFFA5 and 0x000000A5.
- SH 0x00008001 @0x32, then LH @0x32 and LHU @0x30 (word preloaded 0) → `mem_bw`=1100; responses 0xFFFF8001 and 0x00000000.
- With `LSU_ALIGN_CHK_EN`: LW @0x41, SH @0x43, load `funct3`=011 → `rsp_err` 01, 01, 10 at T+1; `rsp_rdata`=0; no strobe. Without the macro: LW @0x41 returns word @0x40.
- Hold `rsp_ready`=0 for 5 cycles after a load with `req_valid` held high → `rsp_valid` and data stable, `req_ready`=0 throughout; next request accepted the cycle after the response handshake.
- Assert `rst_n`=0 during ACCESS of SW 0x12345678 @0x50 → strobes drop immediately, LW @0x50 after reset returns the prior contents, outputs at reset values.
